// File: rtl/seg_display_decoder.sv
// Passive observer of a multiplexed active-low 7-segment bus; rebuilds
// per-position digit codes and publishes them as consistent frames.
//
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   an[3:0]        anode lines, active-low, bit 3 = leftmost position
//   seg[6:0]       segment lines {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low
//   digits[15:0]   published codes, position k at [4k+3:4k] (F blank, E bad)
//   dp_flags[3:0]  published decimal points, 1 = lit
//   digit_valid    positions present in the published frame
//   frame_valid    a frame has been published since reset / last loss
//   frame_strobe   one-cycle pulse when the published outputs update
//   pattern_err    one-cycle pulse on an accepted illegal sample
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_flags,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        frame_strobe,
    output logic        pattern_err
);

    localparam int RW = $clog2(STABLE_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_ACC = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state, state_nxt;
    logic [3:0]      s_an;
    logic [6:0]      s_seg;
    logic            s_dp;
    logic [RW-1:0]   run;
    logic [TW-1:0]   timer;
    logic [3:0][3:0] live_code;
    logic [3:0]      live_dp;
    logic [3:0]      seen;

    logic       changed, accept, blank, multi, digit_acc, timeout;
    logic [3:0] lows, code;
    logic [1:0] pos;
    logic       err_nxt, publish, restart, set_bit, clr_seen, loss, tmr_clr;

    assign changed   = {an, seg, dp} != {s_an, s_seg, s_dp};
    assign accept    = run == RUN_ACC;
    assign lows      = ~s_an;
    assign blank     = lows == 4'h0;
    // More than one bit set <=> clearing the lowest set bit leaves a residue.
    assign multi     = (lows & 4'(lows - 4'd1)) != 4'h0;
    assign digit_acc = accept && !blank && !multi;
    // An accept in the same cycle always wins over the timeout.
    assign timeout   = (timer == TMO) && !accept;
    assign err_nxt   = accept && (multi || (digit_acc && code == 4'hE));

    always_comb begin
        pos = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (lows[k]) pos = 2'(k);
        end
    end

    always_comb begin
        case (s_seg)
            7'h40:   code = 4'h0;
            7'h79:   code = 4'h1;
            7'h24:   code = 4'h2;
            7'h30:   code = 4'h3;
            7'h19:   code = 4'h4;
            7'h12:   code = 4'h5;
            7'h02:   code = 4'h6;
            7'h78:   code = 4'h7;
            7'h00:   code = 4'h8;
            7'h10:   code = 4'h9;
            7'h7F:   code = 4'hF;
            default: code = 4'hE;
        endcase
    end

    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        restart   = 1'b0;
        set_bit   = 1'b0;
        clr_seen  = 1'b0;
        loss      = 1'b0;
        tmr_clr   = accept;
        case (state)
            IDLE: begin
                if (digit_acc) begin
                    restart   = 1'b1;
                    state_nxt = COLLECT;
                end else if (timeout && blank) begin
                    loss = 1'b1;
                end
            end
            COLLECT: begin
                if (digit_acc) begin
                    if (seen[pos]) begin
                        publish = 1'b1;
                        restart = 1'b1;
                    end else begin
                        set_bit = 1'b1;
                    end
                end else if (timeout) begin
                    publish   = 1'b1;
                    clr_seen  = 1'b1;
                    state_nxt = IDLE;
                    // Restart so the loss check in IDLE gets a full window.
                    tmr_clr   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_an         <= 4'hF;
            s_seg        <= 7'h7F;
            s_dp         <= 1'b1;
            run          <= RW'(1);
            timer        <= '0;
            live_code    <= {4{4'hF}};
            live_dp      <= 4'h0;
            seen         <= 4'h0;
            digits       <= 16'hFFFF;
            dp_flags     <= 4'h0;
            digit_valid  <= 4'h0;
            frame_valid  <= 1'b0;
            frame_strobe <= 1'b0;
            pattern_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            s_an         <= an;
            s_seg        <= seg;
            s_dp         <= dp;
            frame_strobe <= publish;
            pattern_err  <= err_nxt;

            if (changed) run <= RW'(1);
            else if (run != RUN_MAX) run <= run + RW'(1);

            if (tmr_clr) timer <= '0;
            else if (timer != TMO) timer <= timer + TW'(1);

            if (publish) begin
                for (int k = 0; k < 4; k++) begin
                    if (seen[k]) begin
                        digits[4*k +: 4] <= live_code[k];
                        dp_flags[k]      <= live_dp[k];
                    end
                end
                digit_valid <= seen;
                frame_valid <= 1'b1;
            end else if (loss) begin
                digit_valid <= 4'h0;
                frame_valid <= 1'b0;
            end

            if (digit_acc) begin
                live_code[pos] <= code;
                live_dp[pos]   <= ~s_dp;
            end

            if (restart) seen <= 4'(4'd1 << pos);
            else if (set_bit) seen[pos] <= 1'b1;
            else if (clr_seen) seen <= 4'h0;
        end
    end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Bench for seg_display_decoder: directed display scenarios plus
// randomized bus activity against a frame-level reference model.
module tb_seg_display_decoder;

    localparam int STABLE = 2;
    localparam int TMO    = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_flags;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        frame_strobe;
    logic        pattern_err;

    always #5 clock = ~clock;

    seg_display_decoder #(
        .STABLE_CYCLES(STABLE),
        .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .an(an),
        .seg(seg),
        .dp(dp),
        .digits(digits),
        .dp_flags(dp_flags),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .frame_strobe(frame_strobe),
        .pattern_err(pattern_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    int n_err    = 0;

    always @(posedge clock) begin
        #1;
        if (frame_strobe) n_strobe++;
        if (pattern_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: works on whole accepted samples, not cycles.
    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    bit          m_collect;
    logic [3:0]  m_live [4];
    bit          m_ldp [4];
    logic [3:0]  m_seen;
    logic [15:0] m_digits;
    logic [3:0]  m_dpf;
    logic [3:0]  m_dv;
    bit          m_fv;
    logic [11:0] m_last;
    int          e_strobe;
    int          e_err;

    task automatic m_reset();
        m_collect = 0;
        for (int k = 0; k < 4; k++) begin
            m_live[k] = 4'hF;
            m_ldp[k]  = 0;
        end
        m_seen   = 0;
        m_digits = 16'hFFFF;
        m_dpf    = 0;
        m_dv     = 0;
        m_fv     = 0;
        m_last   = {4'hF, 7'h7F, 1'b1};
    endtask

    task automatic m_publish();
        for (int k = 0; k < 4; k++) begin
            if (m_seen[k]) begin
                m_digits[4*k +: 4] = m_live[k];
                m_dpf[k] = m_ldp[k];
            end
        end
        m_dv = m_seen;
        m_fv = 1;
        e_strobe++;
    endtask

    task automatic m_timeout();
        m_publish();
        m_seen    = 0;
        m_collect = 0;
    endtask

    task automatic m_accept(input logic [3:0] a, input logic [6:0] s,
                            input logic d);
        logic [3:0] lows;
        logic [3:0] c;
        int p;
        lows = ~a;
        if (lows == 0) return;
        if ($countones(lows) > 1) begin
            e_err++;
            return;
        end
        p = 0;
        for (int k = 0; k < 4; k++) if (lows[k]) p = k;
        c = (s == 7'h7F) ? 4'hF : 4'hE;
        for (int i = 0; i < 10; i++) if (pat[i] == s) c = 4'(i);
        if (c == 4'hE) e_err++;
        if (m_collect && m_seen[p]) begin
            m_publish();
            m_seen = 0;
        end
        m_live[p] = c;
        m_ldp[p]  = ~d;
        m_seen[p] = 1;
        m_collect = 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/digits"}, 32'(digits), 32'(m_digits));
        check({tag, "/dp_flags"}, 32'(dp_flags), 32'(m_dpf));
        check({tag, "/digit_valid"}, 32'(digit_valid), 32'(m_dv));
        check({tag, "/frame_valid"}, 32'(frame_valid), 32'(m_fv));
    endtask

    // Drive one bus value for h clocks, then compare against the model.
    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic d, input int h, input string tag);
        int s0;
        int e0;
        s0 = n_strobe;
        e0 = n_err;
        e_strobe = 0;
        e_err = 0;
        an  = a;
        seg = s;
        dp  = d;
        repeat (h) @(negedge clock);
        if (h >= STABLE && {a, s, d} != m_last) m_accept(a, s, d);
        m_last = {a, s, d};
        check({tag, "/strobes"}, 32'(n_strobe - s0), 32'(e_strobe));
        check({tag, "/perr"}, 32'(n_err - e0), 32'(e_err));
        check_outputs(tag);
    endtask

    task automatic blank_hold(input int n);
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        m_last = {4'hF, 7'h7F, 1'b1};
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        an    = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        int s0;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        int         h;
        int         r;

        an    = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        reset = 1'b1;
        m_reset();
        repeat (2) @(negedge clock);
        check("rst/digits", 32'(digits), 32'hFFFF);
        check("rst/dp_flags", 32'(dp_flags), 32'h0);
        check("rst/digit_valid", 32'(digit_valid), 32'h0);
        check("rst/frame_valid", 32'(frame_valid), 32'h0);
        check("rst/strobe", 32'(frame_strobe), 32'h0);
        check("rst/perr", 32'(pattern_err), 32'h0);
        reset = 1'b0;

        // "10.59" with the point on position 2
        s0 = n_strobe;
        for (int n = 0; n < 2; n++) begin
            step(4'b0111, 7'h79, 1'b1, 4, "scan4");
            step(4'b1011, 7'h40, 1'b0, 4, "scan4");
            step(4'b1101, 7'h12, 1'b1, 4, "scan4");
            step(4'b1110, 7'h10, 1'b1, 4, "scan4");
        end
        step(4'b0111, 7'h79, 1'b1, 4, "scan4");
        check("scan4/digits_k", 32'(digits), 32'h1059);
        check("scan4/dp_k", 32'(dp_flags), 32'b0100);
        check("scan4/dv_k", 32'(digit_valid), 32'hF);
        check("scan4/nstrobe_k", 32'(n_strobe - s0), 32'd2);

        // blank bus: partial frame closes, then the frame is lost
        s0 = n_strobe;
        blank_hold(40);
        e_strobe = 0;
        m_timeout();
        m_fv = 0;
        m_dv = 0;
        check("loss/strobes", 32'(n_strobe - s0), 32'd1);
        check_outputs("loss");
        check("loss/fv_k", 32'(frame_valid), 32'h0);

        // three-position scan
        do_reset();
        for (int n = 0; n < 2; n++) begin
            step(4'b0111, 7'h79, 1'b1, 4, "scan3");
            step(4'b1011, 7'h24, 1'b1, 4, "scan3");
            step(4'b1110, 7'h30, 1'b1, 4, "scan3");
        end
        step(4'b0111, 7'h79, 1'b1, 4, "scan3");
        check("scan3/digits_k", 32'(digits), 32'h12F3);
        check("scan3/dv_k", 32'(digit_valid), 32'b1101);

        // one-clock glitch to an illegal pattern is never accepted
        step(4'b0111, 7'h55, 1'b1, 1, "glitch");
        step(4'b0111, 7'h79, 1'b1, 4, "glitch_end");
        check("glitch/digits_k", 32'(digits), 32'h12F3);

        // two anodes low, then an undecodable pattern on position 0
        step(4'b0011, 7'h79, 1'b1, 3, "multi");
        step(4'b1011, 7'h24, 1'b1, 4, "badseg");
        step(4'b1110, 7'h55, 1'b1, 4, "badseg");
        step(4'b0111, 7'h79, 1'b1, 4, "badseg");
        check("badseg/digit0_k", 32'(digits[3:0]), 32'hE);

        // asynchronous reset mid-scan
        an  = 4'b1011;
        seg = 7'h24;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst/digits", 32'(digits), 32'hFFFF);
        check("midrst/dv", 32'(digit_valid), 32'h0);
        check("midrst/fv", 32'(frame_valid), 32'h0);
        check("midrst/dp_flags", 32'(dp_flags), 32'h0);
        an  = 4'hF;
        seg = 7'h7F;
        @(negedge clock);
        reset = 1'b0;
        m_reset();

        // static single-position display closes by timeout
        step(4'b1110, 7'h19, 1'b1, 4, "static");
        s0 = n_strobe;
        repeat (14) @(negedge clock);
        check("static/early", 32'(n_strobe - s0), 32'd0);
        @(negedge clock);
        check("static/strobe", 32'(n_strobe - s0), 32'd1);
        e_strobe = 0;
        m_timeout();
        check_outputs("static");
        check("static/digits_k", 32'(digits), 32'hFFF4);
        s0 = n_strobe;
        repeat (40) @(negedge clock);
        check("static/quiet", 32'(n_strobe - s0), 32'd0);
        blank_hold(40);
        m_fv = 0;
        m_dv = 0;
        check_outputs("static_loss");

        // randomized bus activity
        do_reset();
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
            end else if (r < 90) begin
                a = 4'($urandom);
                while ($countones(~a) < 2) a = 4'($urandom);
            end else begin
                a = 4'hF;
            end
            r = $urandom_range(0, 99);
            if (r < 85) s = pat[$urandom_range(0, 9)];
            else if (r < 92) s = 7'h7F;
            else s = 7'($urandom);
            d = 1'($urandom);
            h = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(3, 6);
            if ({a, s, d} == m_last) d = ~d;
            step(a, s, d, h, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
